madd_msub_ctrl: RTL and testbench

Sequencing controller for the 256-bit modular add/subtract datapath (16-bit word-serial, 16 words per operand). It accepts an operation request, streams operands a, b and modulus p into the datapath's cyclic registers, runs the two 16-cycle arithmetic passes (raw sum/difference, then correction by p), and selects and streams out the reduced 256-bit result. It sits between the modular-arithmetic top level and the datapath, and drives every datapath write-enable, rotate, mux and carry control.

---
 rtl/madd_msub_ctrl.sv | 152 +++++++++++++++
 tb/tb_madd_msub_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/madd_msub_ctrl.sv
// Sequencer for the word-serial 256-bit modular add/subtract datapath:
// operand load, raw pass, correction-by-p pass, then result streaming.
module madd_msub_ctrl #(
  parameter int unsigned NWORDS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  input  logic keep_p,
  input  logic din_valid,
  output logic din_ready,
  input  logic dout_ready,
  output logic dout_valid,
  output logic res_sel,
  output logic busy,
  output logic done,
  input  logic sign_a_b,
  input  logic sign_a_b_p,
  output logic rega_we,
  output logic regb_we,
  output logic regp_we,
  output logic regs0_we,
  output logic regs1_we,
  output logic rega_cyc,
  output logic regb_cyc,
  output logic regp_cyc,
  output logic regs0_cyc,
  output logic regs1_cyc,
  output logic dff1_we,
  output logic carry_sel,
  output logic mux0_sel,
  output logic mux1_sel,
  output logic add_sub
);

  localparam int unsigned CW = $clog2(NWORDS);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_P, PH1, PH2, OUT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wc;
  logic          op_q, keep_q, neg, res_sel_q, done_q;
  logic          adv, last, accept, out_last;

  assign last     = (wc == LAST);
  // done_q doubles as the "first IDLE cycle" marker, so start is ignored then
  assign accept   = (state == IDLE) && start && !done_q;
  assign out_last = (state == OUT) && dout_ready && last;
  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign res_sel  = res_sel_q;

  always_comb begin
    state_nx   = state;
    adv        = 1'b0;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    rega_we    = 1'b0;
    regb_we    = 1'b0;
    regp_we    = 1'b0;
    regs0_we   = 1'b0;
    regs1_we   = 1'b0;
    rega_cyc   = 1'b0;
    regb_cyc   = 1'b0;
    regp_cyc   = 1'b0;
    regs0_cyc  = 1'b0;
    regs1_cyc  = 1'b0;
    dff1_we    = 1'b0;
    carry_sel  = 1'b0;
    mux0_sel   = 1'b0;
    mux1_sel   = 1'b0;
    add_sub    = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = LOAD_A;
      LOAD_A: begin
        din_ready = 1'b1;
        rega_we   = din_valid;
        adv       = din_valid;
        if (din_valid && last) state_nx = LOAD_B;
      end
      LOAD_B: begin
        din_ready = 1'b1;
        regb_we   = din_valid;
        adv       = din_valid;
        if (din_valid && last) state_nx = keep_q ? PH1 : LOAD_P;
      end
      LOAD_P: begin
        din_ready = 1'b1;
        regp_we   = din_valid;
        adv       = din_valid;
        if (din_valid && last) state_nx = PH1;
      end
      PH1: begin
        add_sub   = op_q;
        carry_sel = (wc == '0);
        rega_cyc  = 1'b1;
        regb_cyc  = 1'b1;
        regs0_we  = 1'b1;
        dff1_we   = last && !op_q;
        adv       = 1'b1;
        if (last) state_nx = PH2;
      end
      PH2: begin
        mux0_sel  = 1'b1;
        mux1_sel  = 1'b1;
        add_sub   = ~op_q;
        carry_sel = (wc == '0);
        regs0_cyc = 1'b1;
        regp_cyc  = 1'b1;
        regs1_we  = 1'b1;
        adv       = 1'b1;
        if (last) state_nx = OUT;
      end
      OUT: begin
        dout_valid = 1'b1;
        regs0_cyc  = dout_ready;
        regs1_cyc  = dout_ready;
        adv        = dout_ready;
        if (out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wc        <= '0;
      op_q      <= 1'b0;
      keep_q    <= 1'b0;
      neg       <= 1'b0;
      res_sel_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= out_last;
      if (state_nx != state) wc <= '0;
      else if (adv)          wc <= wc + 1'b1;
      if (accept) begin
        op_q   <= op;
        keep_q <= keep_p;
      end
      if (state == PH1 && last && op_q) neg <= sign_a_b;
      // res_sel is cleared on the way back to IDLE so it reads 0 outside OUT
      if (state == PH2 && last)  res_sel_q <= op_q ? neg : ~sign_a_b_p;
      else if (out_last)         res_sel_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_madd_msub_ctrl.sv
// Bench for madd_msub_ctrl: a behavioural word-serial datapath closes the loop,
// results are checked against 257-bit modular arithmetic.
module tb_madd_msub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, op = 1'b0, keep_p = 1'b0;
  logic din_valid = 1'b0, dout_ready = 1'b0;
  logic din_ready, dout_valid, res_sel, busy, done;
  logic sign_a_b, sign_a_b_p;
  logic rega_we, regb_we, regp_we, regs0_we, regs1_we;
  logic rega_cyc, regb_cyc, regp_cyc, regs0_cyc, regs1_cyc;
  logic dff1_we, carry_sel, mux0_sel, mux1_sel, add_sub;
  logic [15:0] din = '0;

  int n_cmp = 0;
  int n_err = 0;

  madd_msub_ctrl #(.NWORDS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .keep_p(keep_p),
    .din_valid(din_valid), .din_ready(din_ready),
    .dout_ready(dout_ready), .dout_valid(dout_valid),
    .res_sel(res_sel), .busy(busy), .done(done),
    .sign_a_b(sign_a_b), .sign_a_b_p(sign_a_b_p),
    .rega_we(rega_we), .regb_we(regb_we), .regp_we(regp_we),
    .regs0_we(regs0_we), .regs1_we(regs1_we),
    .rega_cyc(rega_cyc), .regb_cyc(regb_cyc), .regp_cyc(regp_cyc),
    .regs0_cyc(regs0_cyc), .regs1_cyc(regs1_cyc),
    .dff1_we(dff1_we), .carry_sel(carry_sel),
    .mux0_sel(mux0_sel), .mux1_sel(mux1_sel), .add_sub(add_sub)
  );

  // Datapath model: word 0 sits in bits [15:0]; writes enter at the top.
  logic [255:0] ra = '0, rb = '0, rp = '0, rs0 = '0, rs1 = '0;
  logic cq = 1'b0, c256 = 1'b0;
  logic [15:0] op0, op1;
  logic cin;
  logic [16:0] sum;

  always_comb begin
    op0 = mux0_sel ? rs0[15:0] : ra[15:0];
    op1 = mux1_sel ? rp[15:0] : rb[15:0];
    cin = carry_sel ? add_sub : cq;
    sum = {1'b0, op0} + {1'b0, (add_sub ? ~op1 : op1)} + {16'd0, cin};
  end
  assign sign_a_b   = ~sum[16];
  assign sign_a_b_p = ~(sum[16] | c256);

  always @(posedge clk) begin
    if (rega_we) ra <= {din, ra[255:16]}; else if (rega_cyc) ra <= {ra[15:0], ra[255:16]};
    if (regb_we) rb <= {din, rb[255:16]}; else if (regb_cyc) rb <= {rb[15:0], rb[255:16]};
    if (regp_we) rp <= {din, rp[255:16]}; else if (regp_cyc) rp <= {rp[15:0], rp[255:16]};
    if (regs0_we) rs0 <= {sum[15:0], rs0[255:16]}; else if (regs0_cyc) rs0 <= {rs0[15:0], rs0[255:16]};
    if (regs1_we) rs1 <= {sum[15:0], rs1[255:16]}; else if (regs1_cyc) rs1 <= {rs1[15:0], rs1[255:16]};
    cq <= sum[16];
    if (dff1_we) c256 <= sum[16];
  end

  localparam int B_BUSY = 19, B_DRDY = 18, B_DVAL = 17, B_DONE = 16, B_RSEL = 15;
  localparam int B_AWE = 14, B_BWE = 13, B_PWE = 12, B_S0WE = 11, B_S1WE = 10;
  localparam int B_ACYC = 9, B_BCYC = 8, B_PCYC = 7, B_S0CYC = 6, B_S1CYC = 5;
  localparam int B_DFF = 4, B_CSEL = 3, B_M0 = 2, B_M1 = 1, B_AS = 0;

  logic [19:0] ctl;
  assign ctl = {busy, din_ready, dout_valid, done, res_sel,
                rega_we, regb_we, regp_we, regs0_we, regs1_we,
                rega_cyc, regb_cyc, regp_cyc, regs0_cyc, regs1_cyc,
                dff1_we, carry_sel, mux0_sel, mux1_sel, add_sub};

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One complete request; abort_at >= 0 asserts rst in that pass cycle instead.
  task automatic run_op(input string tag, input logic o, input logic kp,
                        input logic [255:0] a, input logic [255:0] b, input logic [255:0] p,
                        input int unsigned gap, input bit poke, input int abort_at);
    logic [256:0] s;
    logic [255:0] exp_res, got, src;
    logic         exp_sel;
    logic [19:0]  e;
    int unsigned  w, budget, nload;
    if (!o) begin
      s = {1'b0, a} + {1'b0, b};
      exp_sel = (s >= {1'b0, p});
      if (exp_sel) s = s - {1'b0, p};
      exp_res = s[255:0];
    end else begin
      exp_sel = (a < b);
      exp_res = exp_sel ? (a - b + p) : (a - b);
    end
    got = '0;
    start = 1'b1; op = o; keep_p = kp;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); keep_p = 1'($urandom);
    nload = kp ? 2 : 3;
    budget = 0;
    for (int r = 0; r < int'(nload); r++) begin
      src = (r == 0) ? a : (r == 1) ? b : p;
      w = 0;
      while (w < 16) begin
        din_valid = ($urandom_range(99) >= gap);
        din = src[w*16 +: 16];
        @(negedge clk);
        e = '0;
        e[B_BUSY] = 1'b1; e[B_DRDY] = 1'b1;
        e[B_AWE] = din_valid && r == 0;
        e[B_BWE] = din_valid && r == 1;
        e[B_PWE] = din_valid && r == 2;
        n_cmp++;
        if (ctl !== e) begin
          n_err++;
          $display("FAIL %s load%0d w=%0d ctl: got %b expected %b", tag, r, w, ctl, e);
        end
        if (din_valid) w++;
        @(posedge clk); #1;
        budget++;
        if (budget > 3000) begin
          n_cmp++; n_err++;
          $display("FAIL %s load timeout: got %0d words expected 16", tag, w);
          din_valid = 1'b0;
          return;
        end
      end
    end
    for (int k = 0; k < 32; k++) begin
      start = poke && (k == 3);
      din_valid = 1'($urandom);
      dout_ready = 1'($urandom);
      if (k == abort_at) rst = 1'b1;
      @(negedge clk);
      e = '0;
      e[B_BUSY] = 1'b1;
      if (k < 16) begin
        e[B_AS] = o; e[B_CSEL] = (k == 0);
        e[B_ACYC] = 1'b1; e[B_BCYC] = 1'b1; e[B_S0WE] = 1'b1;
        e[B_DFF] = (k == 15) && !o;
      end else begin
        e[B_AS] = ~o; e[B_CSEL] = (k == 16);
        e[B_M0] = 1'b1; e[B_M1] = 1'b1;
        e[B_S0CYC] = 1'b1; e[B_PCYC] = 1'b1; e[B_S1WE] = 1'b1;
      end
      n_cmp++;
      if (ctl !== e) begin
        n_err++;
        $display("FAIL %s pass k=%0d ctl: got %b expected %b", tag, k, ctl, e);
      end
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst = 1'b0; start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl !== '0) begin
          n_err++;
          $display("FAIL %s after reset ctl: got %b expected %b", tag, ctl, 20'd0);
        end
        @(posedge clk); #1;
        return;
      end
    end
    start = 1'b0; din_valid = 1'b0;
    w = 0; budget = 0;
    while (w < 16) begin
      dout_ready = ($urandom_range(99) >= gap);
      @(negedge clk);
      e = '0;
      e[B_BUSY] = 1'b1; e[B_DVAL] = 1'b1; e[B_RSEL] = exp_sel;
      e[B_S0CYC] = dout_ready; e[B_S1CYC] = dout_ready;
      n_cmp++;
      if (ctl !== e) begin
        n_err++;
        $display("FAIL %s out w=%0d ctl: got %b expected %b", tag, w, ctl, e);
      end
      if (dout_ready) begin
        got[w*16 +: 16] = res_sel ? rs1[15:0] : rs0[15:0];
        w++;
      end
      @(posedge clk); #1;
      budget++;
      if (budget > 3000) begin
        n_cmp++; n_err++;
        $display("FAIL %s out timeout: got %0d words expected 16", tag, w);
        dout_ready = 1'b0;
        return;
      end
    end
    dout_ready = 1'b0;
    if (poke) begin start = 1'b1; op = o; end
    @(negedge clk);
    e = '0; e[B_DONE] = 1'b1;
    n_cmp++;
    if (ctl !== e) begin
      n_err++;
      $display("FAIL %s done pulse ctl: got %b expected %b", tag, ctl, e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ctl !== '0) begin
      n_err++;
      $display("FAIL %s idle after done ctl: got %b expected %b", tag, ctl, 20'd0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (got !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h expected %h", tag, got, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); op = 1'($urandom); keep_p = 1'($urandom);
      din_valid = 1'($urandom); dout_ready = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (ctl !== '0) begin
        n_err++;
        $display("FAIL reset ctl: got %b expected %b", ctl, 20'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl !== '0) begin
        n_err++;
        $display("FAIL idle hold ctl: got %b expected %b", ctl, 20'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    run_op("add_5_3_7", 1'b0, 1'b0, 256'd5, 256'd3, 256'd7, 0, 1'b0, -1);
  endtask

  task automatic test_carry256();
    logic [255:0] p;
    p = '1;
    p = p - 256'd188;
    run_op("carry256_add", 1'b0, 1'b0, p - 256'd1, p - 256'd1, p, 0, 1'b0, -1);
    n_cmp++;
    if (c256 !== 1'b1) begin
      n_err++;
      $display("FAIL carry256 flag: got %b expected 1", c256);
    end
    run_op("keep_p_sub_3_5", 1'b1, 1'b1, 256'd3, 256'd5, p, 0, 1'b0, -1);
  endtask

  task automatic test_sub_edges();
    run_op("sub_4_4_7", 1'b1, 1'b0, 256'd4, 256'd4, 256'd7, 0, 1'b0, -1);
    run_op("sub_3_5_7", 1'b1, 1'b0, 256'd3, 256'd5, 256'd7, 0, 1'b0, -1);
  endtask

  task automatic test_flow_control();
    logic [255:0] a, b, p;
    p = rnd256(); p[255] = 1'b1;
    a = rnd256() % p;
    b = rnd256() % p;
    run_op("flow_nogap_add", 1'b0, 1'b0, a, b, p, 0, 1'b0, -1);
    run_op("flow_gap_add", 1'b0, 1'b0, a, b, p, 40, 1'b1, -1);
    run_op("flow_gap_sub", 1'b1, 1'b1, a, b, p, 40, 1'b1, -1);
  endtask

  task automatic test_reset_mid_ph2();
    run_op("abort_ph2", 1'b0, 1'b0, 256'd6, 256'd2, 256'd7, 0, 1'b0, 20);
    run_op("after_abort_add", 1'b0, 1'b0, 256'd5, 256'd3, 256'd7, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [255:0] a, b, p;
    logic kp, o;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      kp = (i > 0) && 1'($urandom);
      if (!kp) begin
        p = rnd256();
        p[255] = 1'($urandom);
        p[200] = 1'b1;
      end
      a = rnd256() % p;
      b = ($urandom_range(3) == 0) ? a : rnd256() % p;
      o = 1'($urandom);
      run_op($sformatf("rand%0d", i), o, kp, a, b, p, 20, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry256();
    test_sub_edges();
    test_flow_control();
    test_reset_mid_ph2();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
